fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end with a PC generator, handshaked instruction-memory
//  port and a DEPTH-entry prefetch queue. Keeps issuing fetches while the decoder is frozen,
//  tags each instruction with its PC, and on a redirect (update_pc) flushes the queue and
//  discards responses still in flight. Sits between instruction memory and the decode stage.
// PARAMETERS
//  INSTR_W   16  instruction width in bits
//  PC_W      32  program-counter width in bits
//  DEPTH     4   queue entries = max requests in flight plus buffered; power of 2, >= 2
//  PC_STEP   1   PC increment per fetched instruction
//  RESET_PC  0   fetch PC value after reset
// PORTS
//  clk          in   1        clock, rising edge
//  reset_n      in   1        asynchronous, active-low reset
//  freeze       in   1        decode stalled; head entry is not consumed
//  update_pc    in   1        redirect strobe (branch/jump)
//  pc_new       in   PC_W     redirect target, sampled when update_pc=1
//  imem_req     out  1        fetch request valid
//  imem_addr    out  PC_W     fetch address (= fetch PC)
//  imem_gnt     in   1        memory accepts request this cycle
//  imem_rvalid  in   1        read data valid; responses return in request order
//  imem_rdata   in   INSTR_W  read data
//  out_valid    out  1        head instruction available
//  data         out  INSTR_W  head instruction
//  pc           out  PC_W     PC of head instruction
// BEHAVIOUR
//  - Reset (reset_n=0, async): fetch_pc=RESET_PC; queue empty; drop_cnt=0; imem_req=0,
//    out_valid=0, data=0, pc=0. Reset mid-transfer clears all state; late imem_rvalid is ignored.
//  - Queue is a ring: slot allocated at issue (PC stored), data filled on response, freed on pop.
//    Pointers are log2(DEPTH) bits and wrap naturally; occupancy counter is $clog2(DEPTH+1) bits.
//  - imem_req = (alloc + drop_cnt < DEPTH) & ~update_pc; imem_addr = fetch_pc. Combinational.
//  - Issue (imem_req & imem_gnt): allocate slot with pc=fetch_pc; fetch_pc += PC_STEP (mod 2^PC_W).
//  - Response (imem_rvalid): if drop_cnt>0, discard it and decrement drop_cnt; otherwise fill the
//    oldest unfilled slot with imem_rdata. Zero-latency response (same cycle as gnt) is illegal.
//  - out_valid = head slot filled & ~update_pc; data/pc = head contents (0 when queue empty).
//  - Pop = out_valid & ~freeze: head freed at the clock edge. Issue, response and pop can all
//    occur in one cycle; counters are updated with their net effect.
//  - Full: alloc + drop_cnt = DEPTH -> imem_req=0 until a pop or a discarded response.
//  - Redirect (update_pc=1), priority over everything: no issue, no pop that cycle; next edge:
//    queue flushed, fetch_pc=pc_new, drop_cnt = (drop_cnt + slots issued but unfilled)
//    - (1 if imem_rvalid this cycle). Requests resume the next cycle. Back-to-back redirects legal.
//  - freeze only blocks pops; fetching continues until the queue is full.
// TESTING
//  1 Reset, 1-cycle mem, freeze=0 -> imem_addr 0,1,2,...; out_valid from cycle 3; pc/data pairs match.
//  2 freeze=1 for 10 cycles, DEPTH=4 -> exactly 4 requests granted, imem_req=0 afterwards, head
//    stable at pc 0; release freeze -> pcs 0,1,2,3,4 popped in order with no gap or duplicate.
//  3 3 requests in flight (2-cycle latency), update_pc=1, pc_new=0x40 -> 3 responses discarded,
//    first out_valid shows pc=0x40 with its own data.
//  4 update_pc on the same cycle as imem_rvalid and a would-be pop -> pop suppressed, response
//    counted as dropped, drop_cnt correct, no stale instruction emerges.
//  5 PC_W=8, RESET_PC=8'hFE, PC_STEP=1 -> fetch addresses FE,FF,00,01 (wrap).
//  6 reset_n pulsed low mid-stream with 2 in flight -> outputs 0 immediately (async); later
//    rvalid ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, handshaked imem port and a DEPTH-entry
// prefetch ring whose slots are allocated at issue, filled on response and freed on pop.
module fetch_queue #(
  parameter int              INSTR_W  = 16,
  parameter int              PC_W     = 32,
  parameter int              DEPTH    = 4,
  parameter int              PC_STEP  = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               freeze,
  input  logic               update_pc,
  input  logic [PC_W-1:0]    pc_new,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  output logic [INSTR_W-1:0] data,
  output logic [PC_W-1:0]    pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PC_W-1:0]    fetch_pc;
  logic [AW-1:0]      head_ptr, alloc_ptr, fill_ptr;
  logic [CW-1:0]      alloc_cnt, pend_cnt, drop_cnt;
  logic [DEPTH-1:0]   filled, filled_next;
  logic [INSTR_W-1:0] data_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem   [DEPTH];

  logic [CW:0]   inflight, redir_sum, redir_adj;
  logic          issue, resp_drop, resp_fill, head_ok, pop;

  // Slots owed to the memory (allocated or awaiting a discarded response) bound new requests.
  assign inflight  = {1'b0, alloc_cnt} + {1'b0, drop_cnt};
  assign imem_req  = reset_n & ~update_pc & (inflight < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign issue     = imem_req & imem_gnt;

  assign resp_drop = imem_rvalid & (drop_cnt != '0);
  assign resp_fill = imem_rvalid & (drop_cnt == '0) & (pend_cnt != '0);

  assign head_ok   = (alloc_cnt != '0);
  assign out_valid = head_ok & filled[head_ptr] & ~update_pc;
  assign pop       = out_valid & ~freeze;
  assign data      = head_ok ? data_mem[head_ptr] : '0;
  assign pc        = head_ok ? pc_mem[head_ptr]   : '0;

  // On redirect every unfilled slot becomes a response to throw away, less the one arriving now.
  assign redir_sum = {1'b0, drop_cnt} + {1'b0, pend_cnt};
  assign redir_adj = (imem_rvalid && redir_sum != '0) ? redir_sum - 1'b1 : redir_sum;

  always_comb begin
    filled_next = filled;
    if (issue)     filled_next[alloc_ptr] = 1'b0;
    if (pop)       filled_next[head_ptr]  = 1'b0;
    if (resp_fill) filled_next[fill_ptr]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc  <= RESET_PC;
      head_ptr  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= '0;
      filled    <= '0;
    end else if (update_pc) begin
      fetch_pc  <= pc_new;
      head_ptr  <= '0;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= redir_adj[CW-1:0];
      filled    <= '0;
    end else begin
      if (issue) begin
        fetch_pc  <= fetch_pc + PC_W'(PC_STEP);
        alloc_ptr <= alloc_ptr + AW'(1);
      end
      if (resp_fill) fill_ptr <= fill_ptr + AW'(1);
      if (pop)       head_ptr <= head_ptr + AW'(1);
      if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
      alloc_cnt <= alloc_cnt + CW'(issue) - CW'(pop);
      pend_cnt  <= pend_cnt + CW'(issue) - CW'(resp_fill);
      filled    <= filled_next;
    end
  end

  // Payload storage carries no reset; the slot state above decides what is visible.
  always_ff @(posedge clk) begin
    if (issue)     pc_mem[alloc_ptr]  <= fetch_pc;
    if (resp_fill) data_mem[fill_ptr] <= imem_rdata;
  end

endmodule
